// File: rtl/square_pkg.sv
// Shared definitions for the sequential squarer: FSM encoding, counter sizing
// and parameter legality.
package square_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_e;

    // Bits needed to count 0..value-1; never less than one bit.
    function automatic int unsigned clog2(input int unsigned value);
        int unsigned result;
        int unsigned v;
        result = 0;
        v      = (value > 0) ? value - 1 : 0;
        while (v > 0) begin
            result++;
            v = v >> 1;
        end
        return (result == 0) ? 1 : result;
    endfunction

    function automatic bit params_ok(input int unsigned width, input int unsigned acc_w);
        return (width >= 2) && (width <= 32) && (acc_w >= 2 * width);
    endfunction

endpackage

// File: rtl/square_seq_sum_acc.sv
// Running sum of squares: wrap-around adder with sticky carry-out flag.
// A clear in the same cycle as an add yields clear-then-add.
module sum_acc #(
    parameter int unsigned PROD_W = 16,
    parameter int unsigned ACC_W  = 20
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clr_i,
    input  logic              add_i,
    input  logic [PROD_W-1:0] addend_i,
    output logic [ACC_W-1:0]  sum_o,
    output logic              ovf_o
);

    logic [ACC_W-1:0] sum_q, sum_d;
    logic             ovf_q, ovf_d;
    logic [ACC_W-1:0] base;
    logic             base_ovf;
    logic [ACC_W:0]   total;

    assign base     = clr_i ? '0 : sum_q;
    assign base_ovf = clr_i ? 1'b0 : ovf_q;
    assign total    = {1'b0, base} + (ACC_W + 1)'(addend_i);

    always_comb begin
        sum_d = base;
        ovf_d = base_ovf;
        if (add_i) begin
            sum_d = total[ACC_W-1:0];
            ovf_d = base_ovf | total[ACC_W];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sum_q <= '0;
            ovf_q <= 1'b0;
        end else begin
            sum_q <= sum_d;
            ovf_q <= ovf_d;
        end
    end

    assign sum_o = sum_q;
    assign ovf_o = ovf_q;

endmodule

// File: rtl/square_seq.sv
// Sequential squarer: one shift-add step per multiplier bit, fixed WIDTH-cycle
// latency, optional accumulation of results into a running sum.
module square_seq
    import square_pkg::*;
#(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned ACC_W = 2 * WIDTH + 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [WIDTH-1:0]     in_data,
    input  logic                 in_accum,
    input  logic                 sum_clr,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [2*WIDTH-1:0]   out_data,
    output logic [ACC_W-1:0]     sum,
    output logic                 sum_ovf
);

    localparam int unsigned CNT_W = clog2(WIDTH);
    localparam int unsigned PW    = 2 * WIDTH;

    if (!params_ok(WIDTH, ACC_W)) begin : g_param_check
        $error("square_seq: WIDTH must be 2..32 and ACC_W >= 2*WIDTH");
    end

    state_e           state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] m_q, m_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             acc_flag_q, acc_flag_d;
    logic [PW-1:0]    prod_q, prod_d;
    logic [PW-1:0]    out_data_q, out_data_d;

    logic [PW-1:0]    partial;
    logic [PW-1:0]    final_prod;
    logic             last_step;
    logic             acc_add;

    assign last_step  = (cnt_q == CNT_W'(WIDTH - 1));
    assign partial    = m_q[0] ? (PW'(a_q) << cnt_q) : '0;
    assign final_prod = prod_q + partial;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_q        <= '0;
            m_q        <= '0;
            cnt_q      <= '0;
            acc_flag_q <= 1'b0;
            prod_q     <= '0;
            out_data_q <= '0;
        end else begin
            a_q        <= a_d;
            m_q        <= m_d;
            cnt_q      <= cnt_d;
            acc_flag_q <= acc_flag_d;
            prod_q     <= prod_d;
            out_data_q <= out_data_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        a_d        = a_q;
        m_d        = m_q;
        cnt_d      = cnt_q;
        acc_flag_d = acc_flag_q;
        prod_d     = prod_q;
        out_data_d = out_data_q;
        unique case (state_q)
            IDLE: begin
                if (in_valid) begin
                    a_d        = in_data;
                    m_d        = in_data;
                    acc_flag_d = in_accum;
                    prod_d     = '0;
                    cnt_d      = '0;
                    state_d    = CALC;
                end
            end
            CALC: begin
                prod_d = final_prod;
                m_d    = m_q >> 1;
                cnt_d  = cnt_q + CNT_W'(1);
                if (last_step) begin
                    out_data_d = final_prod;
                    state_d    = DONE;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // in_ready depends only on state, so there is no out_ready -> in_ready path.
    always_comb begin
        in_ready  = (state_q == IDLE);
        out_valid = (state_q == DONE);
        acc_add   = (state_q == CALC) && last_step && acc_flag_q;
    end

    sum_acc #(
        .PROD_W (PW),
        .ACC_W  (ACC_W)
    ) u_sum_acc (
        .clk      (clk),
        .rst_n    (rst_n),
        .clr_i    (sum_clr),
        .add_i    (acc_add),
        .addend_i (final_prod),
        .sum_o    (sum),
        .ovf_o    (sum_ovf)
    );

    assign out_data = out_data_q;

endmodule

// File: tb/tb_square_seq.sv
// Scoreboard bench for square_seq: two configurations (8-bit, and 4-bit with a
// narrow accumulator) driven with directed and random operands.
module tb_square_seq;

    logic        clk;
    int          checks;
    int          errors;
    int unsigned cyc;

    initial begin
        clk    = 1'b0;
        checks = 0;
        errors = 0;
    end
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input int w, input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL w%0d %s: got %0d, expected %0d (cycle %0d)", w, name, act, exp, cyc);
        end
    endtask

    for (genvar g = 0; g < 2; g++) begin : g_cfg
        localparam int W  = (g == 0) ? 8 : 4;
        localparam int AW = (g == 0) ? 2 * W + 4 : 8;

        typedef struct {
            longint      data;
            longint      sum;
            bit          ovf;
            int unsigned due;
        } exp_t;

        exp_t          sb[$];
        bit            done;
        longint        model_sum;
        bit            model_ovf;

        logic          rst_n;
        logic          in_valid;
        logic          in_ready;
        logic [W-1:0]  in_data;
        logic          in_accum;
        logic          sum_clr;
        logic          out_valid;
        logic          out_ready;
        logic [2*W-1:0] out_data;
        logic [AW-1:0] sum;
        logic          sum_ovf;

        square_seq #(
            .WIDTH (W),
            .ACC_W (AW)
        ) dut (
            .clk       (clk),
            .rst_n     (rst_n),
            .in_valid  (in_valid),
            .in_ready  (in_ready),
            .in_data   (in_data),
            .in_accum  (in_accum),
            .sum_clr   (sum_clr),
            .out_valid (out_valid),
            .out_ready (out_ready),
            .out_data  (out_data),
            .sum       (sum),
            .sum_ovf   (sum_ovf)
        );

        // mode 0: no clear; 1: clear on the accumulate edge; 2: clear during CALC.
        task automatic issue(input longint d, input bit acc, input int unsigned mode, input bit push);
            int unsigned waited;
            int unsigned acc_cyc;
            longint      p;
            longint      lim;
            exp_t        e;
            p        = d * d;
            lim      = longint'(1) << AW;
            waited   = 0;
            in_valid = 1'b1;
            in_data  = W'(d);
            in_accum = acc;
            while (waited < 200) begin
                @(negedge clk);
                if (in_ready) break;
                waited++;
            end
            if (waited >= 200) begin
                checks++;
                errors++;
                $display("FAIL w%0d accept_timeout: operand %0d not accepted within 200 cycles", W, d);
                in_valid = 1'b0;
                return;
            end
            @(posedge clk);
            #1;
            acc_cyc  = cyc;
            in_valid = 1'b0;
            if (push) begin
                if (mode != 0) begin
                    model_sum = 0;
                    model_ovf = 1'b0;
                end
                if (acc) begin
                    model_sum = model_sum + p;
                    if (model_sum >= lim) begin
                        model_sum = model_sum - lim;
                        model_ovf = 1'b1;
                    end
                end
                e.data = p;
                e.sum  = model_sum;
                e.ovf  = model_ovf;
                e.due  = acc_cyc + W;
                sb.push_back(e);
            end
            if (mode == 2) begin
                sum_clr = 1'b1;
                @(posedge clk);
                #1;
                sum_clr = 1'b0;
            end else if (mode == 1) begin
                repeat (W - 1) @(posedge clk);
                #1;
                sum_clr = 1'b1;
                @(posedge clk);
                #1;
                sum_clr = 1'b0;
            end
        endtask

        initial begin : stim
            int unsigned gap;
            int unsigned sel;
            done      = 1'b0;
            model_sum = 0;
            model_ovf = 1'b0;
            rst_n     = 1'b0;
            in_valid  = 1'b0;
            in_data   = '0;
            in_accum  = 1'b0;
            sum_clr   = 1'b0;
            repeat (2) @(posedge clk);
            #1;
            check(W, "reset_in_ready", in_ready, 1);
            check(W, "reset_out_valid", out_valid, 0);
            check(W, "reset_out_data", out_data, 0);
            check(W, "reset_sum", sum, 0);
            check(W, "reset_sum_ovf", sum_ovf, 0);
            rst_n = 1'b1;

            if (W == 8) begin
                issue(255, 0, 0, 1);
                issue(3, 1, 0, 1);
                issue(4, 1, 1, 1);
                issue(0, 1, 0, 1);
            end else begin
                issue(15, 1, 0, 1);
                issue(15, 1, 0, 1);
                for (int d = 0; d < 16; d++) issue(d, 0, 0, 1);
                issue(1, 1, 2, 1);
            end

            repeat (60) begin
                gap = $urandom_range(0, 2);
                repeat (gap) @(posedge clk);
                #1;
                sel = $urandom_range(0, 9);
                issue($urandom_range(0, (1 << W) - 1), 1'($urandom_range(0, 1)),
                      (sel == 8) ? 1 : (sel == 9) ? 2 : 0, 1);
            end

            for (int i = 0; i < 500 && sb.size() != 0; i++) @(negedge clk);
            check(W, "drain_queue_empty", sb.size(), 0);

            // Abandon an accumulating operand by resetting mid-computation.
            issue(5, 1, 0, 0);
            @(posedge clk);
            #2;
            rst_n = 1'b0;
            #1;
            check(W, "async_reset_in_ready", in_ready, 1);
            check(W, "async_reset_out_valid", out_valid, 0);
            @(posedge clk);
            #1;
            rst_n = 1'b1;
            check(W, "post_reset_in_ready", in_ready, 1);
            check(W, "post_reset_sum", sum, 0);
            check(W, "post_reset_sum_ovf", sum_ovf, 0);
            for (int i = 0; i < W + 3; i++) begin
                @(negedge clk);
                check(W, "no_result_after_reset", out_valid, 0);
            end
            done = 1'b1;
        end

        initial begin : sink
            int hold;
            hold      = 5;
            out_ready = 1'b0;
            forever begin
                @(posedge clk);
                #2;
                if (out_valid && hold > 0) begin
                    out_ready = 1'b0;
                    hold--;
                end else begin
                    out_ready = ($urandom_range(0, 3) != 0);
                end
            end
        end

        initial begin : monitor
            bit prev_stall;
            bit prev_hs;
            bit seen;
            prev_stall = 1'b0;
            prev_hs    = 1'b0;
            seen       = 1'b0;
            forever begin
                @(negedge clk);
                if (!rst_n) begin
                    prev_stall = 1'b0;
                    prev_hs    = 1'b0;
                    seen       = 1'b0;
                    continue;
                end
                if (prev_hs) begin
                    check(W, "valid_drops_after_handshake", out_valid, 0);
                    check(W, "ready_after_handshake", in_ready, 1);
                end else if (prev_stall) begin
                    check(W, "valid_held_during_stall", out_valid, 1);
                end
                if (out_valid) begin
                    check(W, "in_ready_low_in_done", in_ready, 0);
                    if (sb.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL w%0d spurious_result: out_valid=1 with out_data=%0d, expected no result",
                                 W, out_data);
                    end else begin
                        if (!seen) begin
                            check(W, "latency_cycle", cyc, sb[0].due);
                            seen = 1'b1;
                        end
                        check(W, "out_data", out_data, sb[0].data);
                        check(W, "sum", sum, sb[0].sum);
                        check(W, "sum_ovf", sum_ovf, sb[0].ovf);
                        if (out_ready) begin
                            void'(sb.pop_front());
                            seen = 1'b0;
                        end
                    end
                end
                prev_stall = out_valid && !out_ready;
                prev_hs    = out_valid && out_ready;
            end
        end
    end

    initial begin : finisher
        int unsigned t;
        t = 0;
        while (!(g_cfg[0].done && g_cfg[1].done) && t < 20000) begin
            @(posedge clk);
            t++;
        end
        if (t >= 20000) begin
            checks++;
            errors++;
            $display("FAIL watchdog: stimulus incomplete after %0d cycles, expected completion", t);
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/square_seq.md
Name: square_seq

Overview:
Parametrised sequential squarer: accepts an unsigned WIDTH-bit operand over a valid/ready handshake and computes its square with an iterative shift-add datapath, one multiplier bit per cycle.
Optional accumulate mode keeps a running sum of squares, for sum-of-squares and energy calculations.
Replaces fixed-width case-table squaring in datapaths where operand width makes a lookup table impractical.

Parameters:
WIDTH, 8, operand width in bits; legal range 2..32
ACC_W, 2*WIDTH+4, running-sum register width; must be >= 2*WIDTH

Ports:
clk  in  1  single clock; all state updates on the rising edge
rst_n  in  1  reset, asynchronous and active-low
in_valid  in  1  operand valid
in_ready  out  1  block can accept an operand
in_data  in  WIDTH  unsigned operand
in_accum  in  1  sampled with the operand; 1 = add the result into sum
sum_clr  in  1  synchronous clear of sum and sum_ovf
out_valid  out  1  result valid
out_ready  in  1  consumer accepts the result
out_data  out  2*WIDTH  square of the operand
sum  out  ACC_W  running sum of squares
sum_ovf  out  1  sticky overflow flag for sum

Behaviour:
- Reset (rst_n=0, async): state=IDLE, in_ready=1, out_valid=0, out_data=0, sum=0, sum_ovf=0, internal registers=0. Reset mid-computation abandons the operand; no result is produced.
- FSM states: IDLE, CALC, DONE.
- IDLE:
  - in_ready=1.
  - If in_valid: capture a_reg=in_data, m_reg=in_data, acc_flag=in_accum, prod=0, cnt=0, then go to CALC.
- CALC:
  - in_ready=0.
  - Each cycle: if m_reg[0], prod += a_reg<<cnt (2*WIDTH bits; cannot overflow). Then m_reg>>=1 and cnt++.
  - When cnt==WIDTH-1 is processed: go to DONE; out_data <= final prod.
  - If acc_flag: sum <= sum + final prod, modulo 2^ACC_W. Set sum_ovf if the addition carries out.
- DONE:
  - out_valid=1; out_data is held stable while out_ready=0.
  - If out_ready: out_valid drops the next cycle and the FSM goes to IDLE.
  - No combinational in_ready-from-out_ready path: a new operand is accepted no earlier than the cycle after the DONE handshake.
- Latency: out_valid is high in the cycle after the WIDTH-th rising edge following the accepting edge.
  - Throughput: one result per WIDTH+2 cycles with out_ready held at 1.
- out_data keeps its last value after the handshake; it is only meaningful while out_valid=1.
- sum_clr:
  - Honoured in any state; sum=0 and sum_ovf=0 the next cycle.
  - If it coincides with the accumulate update, the result is clear-then-add: sum=prod and sum_ovf=0 (flag is set only if prod itself exceeds ACC_W, which cannot occur).
- in_data=0 gives out_data=0 after the full WIDTH cycles; there is no early termination, so latency is data-independent.
- in_valid while in CALC or DONE is ignored (in_ready=0); the producer must hold its data.

Decomposition:
- Shared package square_pkg holds:
  - state enum: IDLE=2'd0, CALC=2'd1, DONE=2'd2
  - the counter-width function clog2(WIDTH)
  - parameter legality checks
- No sub-module: the FSM, shift-add datapath and accumulator fit in one module.
- Optionally split out a sum_acc sub-module: wrap-around adder, sticky flag and clear priority.

Test Plan:
- WIDTH=3, operand 7, in_accum=0, out_ready=1 -> out_valid 3 edges after accept, out_data=49, sum=0.
- WIDTH=3, exhaustive operands 0..7 back-to-back -> out_data 0,1,4,9,16,25,36,49; each result WIDTH+2 cycles apart.
- WIDTH=8, operand 255, out_ready=0 for 5 cycles -> out_data=65025 held stable and out_valid=1 throughout; in_ready=0 until the cycle after the handshake.
- WIDTH=8, in_accum=1, operands 3 then 4 -> sum=9 then 25; sum_clr pulsed on the second result's update cycle -> sum=16, sum_ovf=0.
- WIDTH=4, ACC_W=8, accumulate 15,15 (225+225) -> sum=194 (450 mod 256), sum_ovf=1 and sticky until sum_clr.
- rst_n low for 1 cycle mid-CALC -> out_valid never asserts for that operand; in_ready=1 and sum=0 right after release.
